debug_dump_unit: RTL and testbench

- Responder to the SoC-level `debug` strobe.
- A rising edge on `debug` starts a snapshot of the architectural state: all general registers, then a window of data memory.
- Each word is emitted on a valid/ready stream for the simulation monitor or a UART bridge.
- The unit sits inside RISCVSoC next to the core and uses dedicated read ports on the register file and data memory.

---
 rtl/dump_pkg.sv | 22 ++
 rtl/dump_edge_det.sv | 18 +
 rtl/debug_dump_unit.sv | 184 ++++++++++++++++++
 tb/tb_debug_dump_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
// Shared constants for the debug dump unit: FSM encoding, word tags and the checksum index.
package dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_REG   = 3'd1,
    ST_RD_MEM   = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_SEND     = 3'd4,
    ST_DONE     = 3'd5
  } dump_state_e;

  localparam logic        TAG_REG  = 1'b0;
  localparam logic        TAG_MEM  = 1'b1;
  localparam logic [15:0] CSUM_IDX = 16'hFFFF;

  // Byte address of memory word idx in a word-aligned window starting at base.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/dump_edge_det.sv
// Registered rising-edge detector with synchronous reset; rise_o is high in the first cycle sig_i is seen high.
module dump_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sig_q <= 1'b0;
    else       sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/debug_dump_unit.sv
// Snapshot of all general registers followed by a data-memory window, streamed on a valid/ready port.
// Define DUMP_CSUM_EN to append a mod-2^32 checksum word (idx 16'hFFFF) after the last memory word.
module debug_dump_unit
  import dump_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          NUM_REGS  = 32,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            debug,
  output logic [4:0]      rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            dm_ren,
  output logic [31:0]     dm_raddr,
  input  logic [XLEN-1:0] dm_rdata,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_tag,
  output logic [15:0]     dump_idx,
  output logic            dump_last,
  output logic            busy
);

  // Stream handshake: a word transfers in a cycle where dump_valid & dump_ready; while
  // dump_valid is high and dump_ready is low, data/tag/idx/last are held unchanged.

  localparam logic [15:0] LAST_REG = 16'(NUM_REGS - 1);
  localparam logic [15:0] LAST_MEM = 16'(MEM_WORDS - 1);

  dump_state_e     state_q, state_d;
  logic [15:0]     idx_q, idx_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            tag_q, tag_d;
  logic [15:0]     oidx_q, oidx_d;
  logic            last_q, last_d;
  logic            start;

`ifdef DUMP_CSUM_EN
  logic [XLEN-1:0] sum_q, sum_d;
  logic            csum_q, csum_d;
`endif

  dump_edge_det u_edge_det (
    .clk_i  (clk),
    .rst_i  (rst),
    .sig_i  (debug),
    .rise_o (start)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      tag_q   <= 1'b0;
      oidx_q  <= '0;
      last_q  <= 1'b0;
`ifdef DUMP_CSUM_EN
      sum_q   <= '0;
      csum_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      oidx_q  <= oidx_d;
      last_q  <= last_d;
`ifdef DUMP_CSUM_EN
      sum_q   <= sum_d;
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    tag_d    = tag_q;
    oidx_d   = oidx_q;
    last_d   = last_q;
`ifdef DUMP_CSUM_EN
    sum_d    = sum_q;
    csum_d   = csum_q;
`endif
    rf_raddr = '0;
    dm_ren   = 1'b0;
    dm_raddr = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Only IDLE looks at the trigger, so edges during a dump are dropped.
        if (start) begin
          state_d = ST_RD_REG;
          idx_d   = '0;
`ifdef DUMP_CSUM_EN
          sum_d   = '0;
          csum_d  = 1'b0;
`endif
        end
      end

      ST_RD_REG: begin
        rf_raddr = idx_q[4:0];
        data_d   = rf_rdata;
        tag_d    = TAG_REG;
        oidx_d   = idx_q;
        last_d   = 1'b0;
        state_d  = ST_SEND;
      end

      ST_RD_MEM: begin
        dm_ren   = 1'b1;
        dm_raddr = word_addr(MEM_BASE, idx_q);
        state_d  = ST_MEM_WAIT;
      end

      ST_MEM_WAIT: begin
        data_d  = dm_rdata;
        tag_d   = TAG_MEM;
        oidx_d  = idx_q;
`ifdef DUMP_CSUM_EN
        last_d  = 1'b0;
`else
        last_d  = (idx_q == LAST_MEM);
`endif
        state_d = ST_SEND;
      end

      ST_SEND: begin
        if (dump_ready) begin
`ifdef DUMP_CSUM_EN
          if (!csum_q) sum_d = sum_q + data_q;
`endif
          if (tag_q == TAG_REG) begin
            if (idx_q == LAST_REG) begin
              idx_d   = '0;
              state_d = ST_RD_MEM;
            end else begin
              idx_d   = idx_q + 16'd1;
              state_d = ST_RD_REG;
            end
          end
`ifdef DUMP_CSUM_EN
          else if (csum_q) begin
            state_d = ST_DONE;
          end else if (idx_q == LAST_MEM) begin
            // Checksum word is loaded directly; the sum includes the word just accepted.
            data_d  = sum_q + data_q;
            oidx_d  = CSUM_IDX;
            last_d  = 1'b1;
            csum_d  = 1'b1;
          end
`else
          else if (idx_q == LAST_MEM) begin
            state_d = ST_DONE;
          end
`endif
          else begin
            idx_d   = idx_q + 16'd1;
            state_d = ST_RD_MEM;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign dump_valid = (state_q == ST_SEND);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign dump_data  = data_q;
  assign dump_tag   = tag_q;
  assign dump_idx   = oidx_q;
  assign dump_last  = last_q;

endmodule

// File: tb/tb_debug_dump_unit.sv
// Directed-sequence bench for debug_dump_unit with randomized data and back-pressure.
module tb_debug_dump_unit;

  localparam int          XLEN     = 32;
  localparam int          NUM_REGS = 32;
  localparam int          MW       = 4;
  localparam logic [31:0] BASE     = 32'h0000_0100;
  localparam int          W        = XLEN + 1 + 16 + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            debug;
  logic [4:0]      rf_raddr;
  logic [XLEN-1:0] rf_rdata;
  logic            dm_ren;
  logic [31:0]     dm_raddr;
  logic [XLEN-1:0] dm_rdata;
  logic            dump_valid;
  logic            dump_ready;
  logic [XLEN-1:0] dump_data;
  logic            dump_tag;
  logic [15:0]     dump_idx;
  logic            dump_last;
  logic            busy;

  logic [XLEN-1:0] rf_arr  [NUM_REGS];
  logic [XLEN-1:0] mem_arr [MW];
  logic [W-1:0]    exp_q [$];
  logic [31:0]     addr_q [$];
  int              vectors = 0;
  int              miscompares = 0;

  // ---------------- clock / DUT / memory models ----------------
  always #5 clk = ~clk;

  debug_dump_unit #(
    .XLEN      (XLEN),
    .NUM_REGS  (NUM_REGS),
    .MEM_BASE  (BASE),
    .MEM_WORDS (MW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .debug      (debug),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .dm_ren     (dm_ren),
    .dm_raddr   (dm_raddr),
    .dm_rdata   (dm_rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_tag   (dump_tag),
    .dump_idx   (dump_idx),
    .dump_last  (dump_last),
    .busy       (busy)
  );

  function automatic logic [XLEN-1:0] mem_word(input logic [31:0] a);
    int j;
    j = int'((a - BASE) >> 2);
    if (j >= 0 && j < MW) return mem_arr[j];
    return 32'hDEAD_BEEF;
  endfunction

  assign rf_rdata = rf_arr[rf_raddr];

  always @(posedge clk) begin
    if (dm_ren) dm_rdata <= mem_word(dm_raddr);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_data(input bit pattern);
    for (int i = 0; i < NUM_REGS; i++) rf_arr[i] = pattern ? 32'h1000 + i : $urandom;
    for (int j = 0; j < MW; j++)       mem_arr[j] = pattern ? 32'hA000 + j : $urandom;
  endtask

  // Reference stream: every register in order, then the memory window, then optional checksum.
  task automatic build_expected();
    logic [XLEN-1:0] sum;
    logic            last;
    sum = '0;
    exp_q.delete();
    addr_q.delete();
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_q.push_back({rf_arr[i], 1'b0, 16'(i), 1'b0});
      sum += rf_arr[i];
    end
    for (int j = 0; j < MW; j++) begin
`ifdef DUMP_CSUM_EN
      last = 1'b0;
`else
      last = (j == MW - 1);
`endif
      exp_q.push_back({mem_arr[j], 1'b1, 16'(j), last});
      addr_q.push_back(BASE + 32'(4 * j));
      sum += mem_arr[j];
    end
`ifdef DUMP_CSUM_EN
    exp_q.push_back({sum, 1'b1, 16'hFFFF, 1'b1});
`endif
  endtask

  // ---------------- driver / monitor ----------------
  task automatic run_dump(input int ready_pct, input int hold, input int repulse_at,
                          input int abort_after);
    int           iter = 0;
    int           accepted = 0;
    int           ren = 0;
    int           first_valid = -1;
    int           extra_valid = 0;
    bit           done = 1'b0;
    bit           aborted = 1'b0;
    bit           prev_stall = 1'b0;
    logic         busy_at1 = 1'b0;
    logic [W-1:0] prev_word = '0;
    logic [W-1:0] obs;
    logic [W-1:0] exp;

    build_expected();
    while (!done && !aborted && iter < 3000) begin
      @(posedge clk); #1;
      debug      = (iter < hold) || (iter == repulse_at);
      dump_ready = (int'($urandom_range(99)) < ready_pct);
      @(negedge clk);
      obs = {dump_data, dump_tag, dump_idx, dump_last};
      if (iter == 1) busy_at1 = busy;
      if (dm_ren) begin
        ren++;
        if (addr_q.size() > 0) check("dm_raddr", 64'(dm_raddr), 64'(addr_q.pop_front()));
      end
      if (prev_stall) check("stall_hold", 64'({dump_valid, obs}), 64'({1'b1, prev_word}));
      if (dump_valid && first_valid < 0) first_valid = iter;
      if (dump_valid && dump_ready) begin
        exp = exp_q.pop_front();
        check("word", 64'(obs), 64'(exp));
        accepted++;
        if (exp_q.size() == 0) done = 1'b1;
        if (accepted == abort_after) aborted = 1'b1;
      end
      prev_stall = dump_valid && !dump_ready;
      prev_word  = obs;
      iter++;
    end
    debug = 1'b0;

    if (aborted) begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_mid_dump", 64'({dump_valid, busy}), 64'(0));
      repeat (3) @(posedge clk);
    end else begin
      check("dump_complete", 64'(done), 64'(1));
      check("first_valid_latency", 64'(first_valid), 64'(2));
      check("busy_after_trigger", 64'(busy_at1), 64'(1));
      @(posedge clk); #1;
      @(negedge clk);
      check("busy_after_last", 64'(busy), 64'(0));
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (dump_valid) extra_valid++;
      end
      check("no_extra_words", 64'(extra_valid), 64'(0));
      check("dm_ren_count", 64'(ren), 64'(MW));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst        = 1'b1;
    debug      = 1'b0;
    dump_ready = 1'b0;
    fill_data(1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", 64'({dump_valid, busy, dm_ren, dump_last, dump_tag}), 64'(0));
    check("reset_data", 64'({dump_data, dump_idx}), 64'(0));
    check("reset_addr", 64'({rf_raddr, dm_raddr}), 64'(0));

    // Basic dump with the fixed pattern and an always-ready consumer.
    run_dump(100, 1, -1, 0);

    // Back-pressure with random data.
    fill_data(1'b0);
    run_dump(30, 1, -1, 0);

    // Held trigger plus a second pulse mid-dump: one dump only.
    fill_data(1'b0);
    run_dump(100, 10, 40, 0);

    // Reset after ten accepted words, then a fresh dump from reg 0.
    fill_data(1'b0);
    run_dump(70, 1, -1, 10);
    run_dump(100, 1, -1, 0);

    // A few more randomized dumps.
    for (int n = 0; n < 3; n++) begin
      fill_data(1'b0);
      run_dump(int'($urandom_range(20, 90)), int'($urandom_range(1, 5)), -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
